// File: rtl/audio_sample_scheduler.sv
// Paces audio_processor at the audio sample rate: one sample per CLK_DIV clocks.
// Samples flow over valid/ready streams. Enables change only at frame boundaries.
module audio_sample_scheduler #(
  parameter int CLK_DIV      = 1042,
  parameter int PROC_LATENCY = 4,
  parameter int FRAME_SIZE   = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [15:0] out_data,
  input  logic [9:0]         en_req,
  output logic [9:0]         en_out,
  output logic signed [15:0] proc_sample,
  input  logic signed [15:0] proc_out,
  input  logic [15:0]        est_freq,
  input  logic [15:0]        target_freq,
  output logic               log_valid,
  output logic [31:0]        log_frame,
  output logic [15:0]        log_est,
  output logic [15:0]        log_target,
  output logic [15:0]        underrun_cnt,
  output logic [15:0]        overrun_cnt,
  output logic               busy
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int SET_W = $clog2(PROC_LATENCY + 1);
  localparam int IDX_W = $clog2(FRAME_SIZE + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(PROC_LATENCY - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_SIZE - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, PUSH} state_t;

  state_t           state;
  logic [DIV_W-1:0] div;
  logic [SET_W-1:0] settle_cnt;
  logic [IDX_W-1:0] sample_idx;
  logic [31:0]      frame;
  logic             tick;
  logic             boundary;

  assign tick     = (div == DIV_LAST);
  assign boundary = (sample_idx == '0);
  assign in_ready = (state == IDLE) && tick && in_valid;
  assign busy     = (state != IDLE);

  // Free-running rate divider; never stalled by a busy pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) div <= '0;
    else        div <= tick ? '0 : div + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      settle_cnt   <= '0;
      sample_idx   <= '0;
      frame        <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      en_out       <= '0;
      proc_sample  <= '0;
      log_valid    <= 1'b0;
      log_frame    <= '0;
      log_est      <= '0;
      log_target   <= '0;
      underrun_cnt <= '0;
      overrun_cnt  <= '0;
    end else begin
      log_valid <= 1'b0;
      // Ticks landing while a sample is still in flight are dropped and counted.
      if (tick && state != IDLE && overrun_cnt != 16'hFFFF)
        overrun_cnt <= overrun_cnt + 16'd1;
      unique case (state)
        IDLE: if (tick) begin
          if (in_valid) begin
            proc_sample <= in_data;
          end else begin
            proc_sample <= '0;
            if (underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
          end
          if (boundary) en_out <= en_req;
          settle_cnt <= '0;
          state      <= SETTLE;
        end
        SETTLE: begin
          settle_cnt <= settle_cnt + 1'b1;
          if (settle_cnt == SET_LAST) state <= CAPTURE;
        end
        CAPTURE: begin
          out_data  <= proc_out;
          out_valid <= 1'b1;
          if (boundary) begin
            log_est    <= est_freq;
            log_target <= target_freq;
            log_frame  <= frame;
            log_valid  <= 1'b1;
            frame      <= frame + 32'd1;
          end
          state <= PUSH;
        end
        PUSH: if (out_ready) begin
          out_valid  <= 1'b0;
          sample_idx <= (sample_idx == IDX_LAST) ? '0 : sample_idx + 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_sample_scheduler.sv
// Scoreboarded bench for audio_sample_scheduler with a one-register processor stand-in.
module tb_audio_sample_scheduler;
  localparam int CLK_DIV = 8;
  localparam int PL      = 2;
  localparam int FS      = 4;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid, in_ready, out_valid, out_ready, log_valid, busy;
  logic [15:0] in_data, out_data, proc_sample, proc_out, est_freq, target_freq;
  logic [15:0] log_est, log_target, underrun_cnt, overrun_cnt;
  logic [9:0]  en_req, en_out;
  logic [31:0] log_frame;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, last_tick = 0, hs_cnt = 0, lf_exp = 0, nlog = 0;
  logic [15:0] exp_q[$];
  logic tb_tick;

  audio_sample_scheduler #(.CLK_DIV(CLK_DIV), .PROC_LATENCY(PL), .FRAME_SIZE(FS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .en_req(en_req), .en_out(en_out), .proc_sample(proc_sample), .proc_out(proc_out),
    .est_freq(est_freq), .target_freq(target_freq), .log_valid(log_valid),
    .log_frame(log_frame), .log_est(log_est), .log_target(log_target),
    .underrun_cnt(underrun_cnt), .overrun_cnt(overrun_cnt), .busy(busy));

  always #5 clk = ~clk;

  // Processor stand-in: output is the input sample registered once.
  always @(posedge clk) proc_out <= proc_sample;

  // Cycle count since reset; the sample-rate tick is the last cycle of each CLK_DIV period.
  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;
  assign tb_tick = (cyc % CLK_DIV) == (CLK_DIV - 1);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // Drive one sample period; acc says whether the scheduler should be idle at this tick.
  task automatic do_tick(input logic v, input logic [15:0] d, input logic acc);
    int n = 0;
    in_valid = v;
    in_data  = d;
    do begin
      @(negedge clk);
      n++;
    end while (!tb_tick && n < 4 * CLK_DIV);
    chk("tick_found", 32'(tb_tick), 1);
    chk("in_ready", 32'(in_ready), 32'(v && acc));
    if (acc) exp_q.push_back(v ? d : 16'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (acc) chk("proc_sample", proc_sample, v ? d : 16'd0);
  endtask

  task automatic wait_drain();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || out_valid) && n < 8 * CLK_DIV);
    chk("drain", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // Output / log monitor, sampling on the falling edge.
  initial begin
    logic ov_prev, or_prev;
    logic [15:0] od_prev;
    ov_prev = 1'b0; or_prev = 1'b1; od_prev = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        hs_cnt = 0; lf_exp = 0; ov_prev = 1'b0; or_prev = 1'b1;
      end else begin
        if (tb_tick) last_tick = cyc;
        if (in_ready && !tb_tick) chk("in_ready_offtick", 32'(in_ready), 0);
        if (out_valid && !ov_prev) chk("latency", cyc - last_tick, PL + 2);
        if (out_valid && ov_prev && !or_prev) chk("out_hold", out_data, od_prev);
        if (log_valid) begin
          chk("log_frame", log_frame, lf_exp);
          chk("log_pos", hs_cnt, lf_exp * FS);
          chk("log_est", log_est, 440);
          chk("log_target", log_target, 466);
          lf_exp++; nlog++;
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) chk("spurious_out", 32'(out_valid), 0);
          else chk("out_data", out_data, exp_q.pop_front());
          hs_cnt++;
        end
        ov_prev = out_valid; or_prev = out_ready; od_prev = out_data;
      end
    end
  end

  initial begin
    int n;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1; en_req = 10'h001;
    est_freq = 16'd440; target_freq = 16'd466;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_en_out", en_out, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_underrun", underrun_cnt, 0);
    chk("rst_overrun", overrun_cnt, 0);
    chk("rst_log_valid", 32'(log_valid), 0);
    rst_n = 1'b1;

    // Streaming, one underrun at sample 3, mid-frame enable request at sample 5.
    for (int k = 0; k < 12; k++) begin
      do_tick(k != 3, 16'(100 * (k + 1)), 1'b1);
      if (k == 0) chk("en_first", en_out, 10'h001);
      if (k == 3) chk("underrun", underrun_cnt, 1);
      if (k == 5) en_req = 10'h3FF;
      if (k == 6 || k == 7) chk("en_hold", en_out, 10'h001);
      if (k == 8) chk("en_boundary", en_out, 10'h3FF);
    end
    wait_drain();

    // Backpressure across three ticks.
    out_ready = 1'b0;
    do_tick(1'b1, 16'd1300, 1'b1);
    for (int k = 0; k < 3; k++) do_tick(1'b1, 16'hBEEF, 1'b0);
    chk("overrun", overrun_cnt, 3);
    chk("underrun_kept", underrun_cnt, 1);
    out_ready = 1'b1;
    do_tick(1'b1, 16'd1400, 1'b1);
    wait_drain();

    // Reset while a result is held in PUSH.
    out_ready = 1'b0;
    do_tick(1'b1, 16'd1500, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 4 * CLK_DIV);
    chk("push_valid", 32'(out_valid), 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst2_out_valid", 32'(out_valid), 0);
    chk("rst2_en_out", en_out, 0);
    chk("rst2_busy", 32'(busy), 0);
    chk("rst2_underrun", underrun_cnt, 0);
    chk("rst2_overrun", overrun_cnt, 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 16'd1600;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready || n >= 4 * CLK_DIV) break;
      n++;
    end
    chk("first_tick", n, CLK_DIV - 1);
    exp_q.push_back(16'd1600);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_drain();
    chk("log_count", nlog, 5);
    chk("end_busy", 32'(busy), 0);
    chk("end_overrun", overrun_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded, want completion");
    $fatal(1, "timeout");
  end
endmodule
